sub_serial_16bit: RTL and testbench

SUB_SERIAL_16BIT -- requirements
Module: sub_serial_16bit

---
 rtl/sub_serial_16bit.sv | 118 +++++++++++
 tb/tb_sub_serial_16bit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/sub_serial_16bit.sv
// sub_serial_16bit: bit-serial subtractor d = a - b - bin, one bit per clock, LSB first.
// Latency: start accepted at E0, bits on E1..E16, done pulses for the cycle after E16.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   start, a, b, bin  - request and operands, captured on the accepting edge
//   busy, done        - operation in progress / one-cycle result-valid pulse
//   d, bout, ovf,zero - registered result flags, updated only on DONE entry
module sub_serial_16bit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;      // minuend shift register, current bit in [0]
  logic [WIDTH-1:0] sb;      // subtrahend shift register, current bit in [0]
  logic [WIDTH-1:0] res;     // difference accumulates from the MSB side
  logic             borrow;
  logic             a_msb;   // operand sign bits kept for the overflow flag
  logic             b_msb;
  logic [CW-1:0]    cnt;

  logic             diff_bit;
  logic             borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  // One full-subtractor cell; res_nxt is the result register after this edge,
  // so on the last bit it is the complete difference.
  always_comb begin
    diff_bit   = sa[0] ^ sb[0] ^ borrow;
    borrow_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
    res_nxt    = {diff_bit, res[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      cnt    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      d      <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
      zero   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= bin;
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
            res    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          borrow <= borrow_nxt;
          res    <= res_nxt;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Visible outputs move only here, so partial results never show on d.
            state <= DONE;
            done  <= 1'b1;
            d     <= res_nxt;
            bout  <= borrow_nxt;
            ovf   <= (a_msb ^ b_msb) & (res_nxt[WIDTH-1] ^ a_msb);
            zero  <= ~|res_nxt;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_serial_16bit.sv
module tb_sub_serial_16bit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [15:0] d;
  logic        bout;
  logic        ovf;
  logic        zero;

  int n_assert = 0;
  int n_fail   = 0;

  sub_serial_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bout  (bout),
    .ovf   (ovf),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb, input logic tbin,
                       output logic [15:0] ed, output logic eb, output logic eo,
                       output logic ez);
    int ua, ub, us, sa, sb, ss;
    ua = ta;
    ub = tb;
    us = ua - ub - int'(tbin);
    sa = $signed(ta);
    sb = $signed(tb);
    ss = sa - sb - int'(tbin);
    ed = us[15:0];
    eb = (us < 0);
    eo = (ss > 32767) || (ss < -32768);
    ez = (ed == 16'h0000);
  endtask

  // Launch one operation and check it. poke>0 re-pulses start (with a=0xFFFF)
  // after that many RUN edges; hold keeps start high through the operation.
  task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tbin, input int poke, input logic hold);
    logic [15:0] ed;
    logic        eb, eo, ez;
    logic [15:0] prev_d;
    int          n;
    model(ta, tb, tbin, ed, eb, eo, ez);
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    prev_d = d;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    chk({tag, "_busy_accept"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!hold && poke > 0 && n == poke) begin
        start = 1'b1;
        a = 16'hFFFF;
      end else if (!hold && poke > 0 && n == poke + 1) begin
        start = 1'b0;
      end
      if (n == 8) chk({tag, "_d_hidden"}, {16'd0, d}, {16'd0, prev_d});
    end
    chk({tag, "_latency"}, n, 32'd16);
    chk({tag, "_d"},    {16'd0, d},    {16'd0, ed});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, eb});
    chk({tag, "_ovf"},  {31'd0, ovf},  {31'd0, eo});
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, "_busy_done"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, "_busy_idle"},  {31'd0, busy}, 32'd0);
    chk({tag, "_d_hold"}, {16'd0, d}, {16'd0, ed});
  endtask

  initial begin
    logic        seen_done;
    logic [15:0] keep_d;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_d",    {16'd0, d},    32'd0);
    chk("rst_flags", {29'd0, bout, ovf, zero}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Directed vectors
    run_op("v029", 16'h0088, 16'h0011, 1'b0, 0, 1'b0);
    // IDLE with start low holds everything
    @(negedge clk); a = 16'hABCD; b = 16'h1111;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_hold_d", {16'd0, d}, 32'h0077);
    chk("idle_hold_busy", {31'd0, busy}, 32'd0);
    run_op("v030",  16'h0011, 16'h0088, 1'b0, 0, 1'b0);
    run_op("v031a", 16'hFFFF, 16'hFFFF, 1'b1, 0, 1'b0);
    run_op("v031b", 16'hFFFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("v032a", 16'h8000, 16'h0001, 1'b0, 0, 1'b0);
    run_op("v032b", 16'h7FFF, 16'hFFFF, 1'b0, 0, 1'b0);
    run_op("ovf_bin", 16'h8000, 16'h0000, 1'b1, 0, 1'b0);

    // Start held high: new op begins on the first IDLE edge
    run_op("hold", 16'h5555, 16'h2AAA, 1'b1, 0, 1'b1);
    @(posedge clk); #1;
    chk("hold_restart_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); start = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("hold_rst_busy", {31'd0, busy}, 32'd0);

    // Randomized operations against the model
    for (int i = 0; i < 20; i++) begin
      run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 0, 1'b0);
    end

    // Second start during RUN ignored
    run_op("v033", 16'h1234, 16'h0034, 1'b0, 5, 1'b0);
    chk("v033_d_exact", {16'd0, d}, 32'h1200);

    // Reset mid-RUN aborts with no done pulse
    @(negedge clk);
    a = 16'h4321; b = 16'h0101; bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_d",    {16'd0, d},    32'd0);
    chk("midrst_flags", {29'd0, bout, ovf, zero}, 32'd0);
    seen_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen_done = 1'b1;
    end
    chk("midrst_no_done", {31'd0, seen_done}, 32'd0);

    // rst beats start on the same edge
    @(negedge clk); rst = 1'b1; start = 1'b1; a = 16'h0F0F; b = 16'h0001;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    chk("rst_prio_busy", {31'd0, busy}, 32'd0);

    // Normal operation resumes after reset
    keep_d = 16'h0F0E;
    run_op("post_rst", 16'h0F0F, 16'h0001, 1'b0, 0, 1'b0);
    chk("post_rst_exact", {16'd0, d}, {16'd0, keep_d});

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
